alu_seq_ctrl: RTL

Program sequencer for the 7-bit accumulator ALU. It holds an 8-entry instruction buffer, loaded over a write port. On `start` it issues one ALU instruction per clock (`alu_opcode`, `alu_operand`) until it reaches END, falls off the end of the buffer, or is halted. It also executes its own loop-control instructions (SETCNT, DJNZ), so short programs run without external stepping. It sits between the host/switch logic and the ALU's opcode and operand inputs.

---
 rtl/alu_seq_if.sv | 30 +++
 rtl/alu_seq_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Host-to-sequencer bundle: program write port, run control, and registered ALU issue/status outputs.
// No handshaking: every signal is sampled or driven once per clock.
interface alu_seq_if #(
  parameter int DEPTH = 8,
  parameter int DW    = 7
);
  localparam int PW = $clog2(DEPTH);

  logic            prog_we;
  logic [PW-1:0]   prog_addr;
  logic [DW+2:0]   prog_data;
  logic            start;
  logic            halt_req;
  logic [2:0]      alu_opcode;
  logic [DW-1:0]   alu_operand;
  logic            busy;
  logic            done;
  logic            prog_err;
  logic [PW-1:0]   pc;

  modport master (
    output prog_we, prog_addr, prog_data, start, halt_req,
    input  alu_opcode, alu_operand, busy, done, prog_err, pc
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, halt_req,
    output alu_opcode, alu_operand, busy, done, prog_err, pc
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Program sequencer: 8-entry buffer issuing one ALU op per clock, with SETCNT/DJNZ loops.
// Latency: start at E0 -> mem[0] on ALU outputs after E1; no backpressure, writes in RUN are dropped.
module alu_seq_ctrl #(
  parameter int DEPTH = 8,
  parameter int DW    = 7
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);

  localparam logic [2:0] OP_SETCNT = 3'd5;
  localparam logic [2:0] OP_DJNZ   = 3'd6;
  localparam logic [2:0] OP_END    = 3'd7;

  typedef struct packed {
    logic [2:0]    op;
    logic [DW-1:0] opr;
  } instr_t;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e        state_q, state_d;
  instr_t        mem_q [DEPTH];
  instr_t        mem_d [DEPTH];
  logic [PW-1:0] pc_q, pc_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [2:0]    opc_q, opc_d;
  logic [DW-1:0] opr_q, opr_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          jump;
  logic          last;
  instr_t        cur;

  assign cur  = mem_q[pc_q];
  assign last = (pc_q == PW'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    opc_d   = '0;
    opr_d   = '0;
    done_d  = 1'b0;
    err_d   = err_q;
    jump    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Write lands before the first decode, so a same-cycle start sees it.
        if (bus.prog_we) mem_d[bus.prog_addr] = bus.prog_data;
        if (bus.start) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      S_RUN: begin
        if (bus.prog_we) err_d = 1'b1;
        if (bus.halt_req) begin
          state_d = S_IDLE;
          pc_d    = '0;
        end else begin
          pc_d = pc_q + 1'b1;
          case (cur.op)
            OP_SETCNT: cnt_d = cur.opr[3:0];
            OP_DJNZ: begin
              if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
                pc_d  = cur.opr[PW-1:0];
                jump  = 1'b1;
              end
            end
            OP_END: ;
            default: begin
              opc_d = cur.op;
              opr_d = cur.opr;
            end
          endcase
          // A taken DJNZ at the last slot is a jump, not a fall-through.
          if (cur.op == OP_END || (last && !jump)) begin
            state_d = S_IDLE;
            pc_d    = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
      opc_q   <= '0;
      opr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      opc_q   <= opc_d;
      opr_q   <= opr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.alu_opcode  = opc_q;
  assign bus.alu_operand = opr_q;
  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = done_q;
  assign bus.prog_err    = err_q;
  assign bus.pc          = pc_q;
endmodule
